// File: rtl/program_loader.sv
// Host-to-instruction-memory loader: takes a 16-bit little-endian word count,
// then packs the following bytes little-endian into words written to consecutive addresses.
module program_loader #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_reset_hold
);

    localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MAX_WORDS = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    logic               r_byte_ready;
    logic               r_mem_we;
    logic               r_busy;
    logic               r_done;
    logic               r_error;
    logic [31:0]        r_mem_address;
    logic [31:0]        r_mem_write_data;
    logic [IDX_W-1:0]   r_index;
    logic [1:0]         r_byte_cnt;
    logic [15:0]        r_count;
    logic [31:0]        r_word;

    logic               w_accept;
    logic [15:0]        w_header;
    logic [31:0]        w_word;
    logic [31:0]        w_wr_addr;
    logic               w_last_word;

    assign w_accept    = byte_valid & r_byte_ready;
    assign w_header    = {byte_data, r_count[7:0]};
    assign w_wr_addr   = BASE_ADDR + (32'(r_index) << 2);
    assign w_last_word = ((32'(r_index) + 32'd1) == {16'd0, r_count});

    // Current byte is merged into its lane so the 4th byte is written without an extra cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_word[8*gi +: 8] = (r_byte_cnt == 2'(gi)) ? byte_data : r_word[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_byte_ready     <= 1'b0;
            r_mem_we         <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_error          <= 1'b0;
            r_mem_address    <= BASE_ADDR;
            r_mem_write_data <= 32'd0;
            r_index          <= '0;
            r_byte_cnt       <= 2'd0;
            r_count          <= 16'd0;
            r_word           <= 32'd0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state      <= S_HDR_LO;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_index      <= '0;
                        r_byte_cnt   <= 2'd0;
                    end
                end
                S_HDR_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= byte_data;
                        r_state      <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= byte_data;
                        if (w_header == 16'd0) begin
                            r_state      <= S_DONE;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                        end else if ({16'd0, w_header} > MAX_WORDS) begin
                            r_state      <= S_ERR;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_error      <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_word     <= w_word;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state          <= S_WRITE;
                            r_byte_ready     <= 1'b0;
                            r_mem_we         <= 1'b1;
                            r_mem_address    <= w_wr_addr;
                            r_mem_write_data <= w_word;
                        end
                    end
                end
                S_WRITE: begin
                    r_index    <= r_index + 1'b1;
                    r_byte_cnt <= 2'd0;
                    if (w_last_word) begin
                        r_state      <= S_DONE;
                        r_byte_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_state      <= S_DATA;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready       = r_byte_ready;
    assign mem_write_enable = r_mem_we;
    assign mem_address      = r_mem_address;
    assign mem_write_data   = r_mem_write_data;
    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign cpu_reset_hold   = reset | r_busy;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a stream-level model predicts every memory write,
// a per-cycle monitor checks strobes and invariants, and a small memory verifies round trips.
module tb_program_loader;

    localparam int          MEM_WORDS = 4096;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_reset_hold;

    program_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_ready       (byte_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .cpu_reset_hold   (cpu_reset_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          wr_count = 0;
    int          consumed = 0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;
    logic        prev_we   = 1'b0;

    logic [31:0] imem [0:MEM_WORDS-1];
    logic [31:0] rd_addr = 32'd0;
    logic [31:0] rd_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // Stream-level model: header N, then N little-endian words at BASE + 4*i.
    task automatic model_push(input bq_t s, input int max_words);
        int n;
        logic [31:0] w;
        n = int'(s[0]) + 256 * int'(s[1]);
        if (n == 0 || n > MEM_WORDS) return;
        for (int i = 0; i < n && i < max_words; i++) begin
            w = 32'(s[2+4*i]) + (32'(s[3+4*i]) * 256) + (32'(s[4+4*i]) * 65536)
                + (32'(s[5+4*i]) * 16777216);
            exp_addr_q.push_back(BASE + 32'(4 * i));
            exp_data_q.push_back(w);
        end
    endtask

    // Instruction memory with registered read.
    always @(posedge clk) begin
        if (mem_write_enable) imem[mem_address[13:2]] <= mem_write_data;
        rd_data <= imem[rd_addr[13:2]];
    end

    // Per-cycle compare process.
    always @(negedge clk) begin
        chk("reset_hold", {31'd0, cpu_reset_hold}, {31'd0, reset | busy});
        if (byte_valid && byte_ready) consumed++;
        if (mem_write_enable) begin
            wr_count++;
            last_addr = mem_address;
            last_data = mem_write_data;
            chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
            chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (exp_addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %08h data %08h want no write",
                         mem_address, mem_write_data);
            end else begin
                chk("wr_addr", mem_address, exp_addr_q.pop_front());
                chk("wr_data", mem_write_data, exp_data_q.pop_front());
            end
        end
        prev_we = mem_write_enable;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        byte_valid = 1'b1;
        byte_data  = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                byte_valid = 1'b0;
                if (gap) begin
                    @(posedge clk);
                    #1;
                end
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL send_byte_timeout: got byte_ready %b want 1 within 100 cycles", byte_ready);
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input string tag, input bq_t s, input bit gap, input int ignore_at);
        int c0;
        int k;
        c0 = consumed;
        pulse_start();
        chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold_after_start"}, {31'd0, cpu_reset_hold}, 32'd1);
        chk({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
        chk({tag, "_error_cleared"}, {31'd0, error}, 32'd0);
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], gap);
            if (i == ignore_at) begin
                pulse_start();
                chk({tag, "_start_ignored"}, {31'd0, busy}, 32'd1);
            end
        end
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || error) break;
        end
        if (k == 20) begin
            total++;
            bad++;
            $display("FAIL %s_finish_timeout: got done=%b error=%b want one of them", tag, done, error);
        end
        chk({tag, "_all_writes_seen"}, 32'(exp_addr_q.size()), 32'd0);
        chk({tag, "_bytes_consumed"}, 32'(consumed - c0), 32'(s.size()));
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t basic;
        bq_t one;
        bq_t prog4;
        bq_t big;
        bq_t hdr0;
        bq_t hdr_err;
        int  w0;
        logic [31:0] w;
        logic [31:0] words4 [4];

        basic   = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        one     = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        hdr0    = '{8'h00, 8'h00};
        hdr_err = '{8'h01, 8'h10};
        words4  = '{32'hCAFEF00D, 32'h00000013, 32'h80000001, 32'h7FFFFFFE};
        prog4   = '{8'h04, 8'h00};
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++) begin
                w = words4[i];
                prog4.push_back(w[8*b +: 8]);
            end

        reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_addr", mem_address, BASE);
        chk("rst_data", mem_write_data, 32'd0);
        chk("rst_hold", {31'd0, cpu_reset_hold}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_hold", {31'd0, cpu_reset_hold}, 32'd0);
        chk("idle_ready", {31'd0, byte_ready}, 32'd0);

        // Basic load, byte_valid held high (also offers a byte during each WRITE).
        model_push(basic, MEM_WORDS);
        chk("model_pin_addr1", exp_addr_q[1], 32'h00000004);
        chk("model_pin_data0", exp_data_q[0], 32'h12345678);
        run_load("basic", basic, 1'b0, -1);
        chk("basic_done", {31'd0, done}, 32'd1);
        chk("basic_last_addr", last_addr, 32'h00000004);
        chk("basic_last_data", last_data, 32'hDEADBEEF);
        chk("basic_wr_count", 32'(wr_count), 32'd2);

        // Gapped stream, with a start pulse in the middle of DATA.
        model_push(basic, MEM_WORDS);
        run_load("gaps", basic, 1'b1, 3);
        chk("gaps_done", {31'd0, done}, 32'd1);
        chk("gaps_last_data", last_data, 32'hDEADBEEF);

        // Restart from DONE.
        model_push(one, MEM_WORDS);
        run_load("restart", one, 1'b0, -1);
        chk("restart_done", {31'd0, done}, 32'd1);
        chk("restart_last_addr", last_addr, 32'h00000000);
        chk("restart_last_data", last_data, 32'h11223344);

        // Zero-length header.
        w0 = wr_count;
        run_load("zero", hdr0, 1'b0, -1);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_no_write", 32'(wr_count - w0), 32'd0);

        // Oversized header N=4097.
        w0 = wr_count;
        run_load("oversize", hdr_err, 1'b0, -1);
        chk("oversize_error", {31'd0, error}, 32'd1);
        chk("oversize_done", {31'd0, done}, 32'd0);
        chk("oversize_ready", {31'd0, byte_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("oversize_no_write", 32'(wr_count - w0), 32'd0);

        // Reset after the 3rd byte of the second word: only the first word is written.
        model_push(basic, 1);
        pulse_start();
        for (int i = 0; i < 9; i++) send_byte(basic[i], 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, byte_ready}, 32'd0);
        chk("midrst_we", {31'd0, mem_write_enable}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_error", {31'd0, error}, 32'd0);
        chk("midrst_addr", mem_address, BASE);
        chk("midrst_data", mem_write_data, 32'd0);
        chk("midrst_hold", {31'd0, cpu_reset_hold}, 32'd1);
        chk("midrst_writes", 32'(exp_addr_q.size()), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        model_push(basic, MEM_WORDS);
        run_load("reload", basic, 1'b0, -1);
        chk("reload_done", {31'd0, done}, 32'd1);
        chk("reload_last_data", last_data, 32'hDEADBEEF);

        // Round trip through the instruction memory.
        model_push(prog4, MEM_WORDS);
        run_load("prog4", prog4, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 32'(4 * i);
            @(posedge clk);
            #1;
            chk("roundtrip_read", rd_data, words4[i]);
        end

        // Full-depth load N=4096.
        big = '{8'h00, 8'h10};
        for (int i = 0; i < MEM_WORDS; i++) begin
            w = 32'h3C000000 + 32'(i) * 32'h00010003;
            for (int b = 0; b < 4; b++) big.push_back(w[8*b +: 8]);
        end
        w0 = wr_count;
        model_push(big, MEM_WORDS);
        run_load("full", big, 1'b0, -1);
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_wr_count", 32'(wr_count - w0), 32'd4096);
        chk("full_last_addr", last_addr, 32'h00003FFC);
        chk("full_last_data", last_data, 32'h3C000000 + 32'd4095 * 32'h00010003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
